pipe_regfile: RTL and testbench

//  Parametrised general-purpose register file for the pipelined MIPS datapath.

---
 rtl/pipe_regfile_pkg.sv | 8 +
 rtl/pipe_regfile_scoreboard.sv | 29 ++
 rtl/pipe_regfile.sv | 60 ++++++
 tb/tb_pipe_regfile.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/pipe_regfile_pkg.sv
// pipe_regfile_pkg: shared widths, zero-register index and register file types
package pipe_regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO = 0;
  typedef logic [DATA_W_DEF-1:0] rf_data_t;
  typedef logic [ADDR_W_DEF-1:0] rf_addr_t;
endpackage

// File: rtl/pipe_regfile_scoreboard.sv
// rf_scoreboard: per-register pending bits, set at issue and cleared at writeback
module rf_scoreboard
  import pipe_regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_en_i,
  input  logic [ADDR_W-1:0]    clr_addr_i,
  input  logic                 set_en_i,
  input  logic [ADDR_W-1:0]    set_addr_i,
  output logic [2**ADDR_W-1:0] pend_o
);
  logic [2**ADDR_W-1:0] pend_q, pend_d;
  // clear first, then set, so a new producer to the same register stays pending
  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) pend_d[clr_addr_i] = 1'b0;
    if (set_en_i) pend_d[set_addr_i] = 1'b1;
    if (ZERO_REG != 0) pend_d[REG_ZERO] = 1'b0;
  end
  // reset drops every pending bit; the flushed pipeline has nothing in flight
  always_ff @(posedge clk_i) begin
    pend_q <= !rst_ni ? '0 : pend_d;
  end
  assign pend_o = pend_q;
endmodule

// File: rtl/pipe_regfile.sv
// pipe_regfile: multi-port register file with write bypass, zero register and pending scoreboard
module pipe_regfile
  import pipe_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  input  logic [NUM_RD-1:0]        rd_use_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_pending_o,
  output logic                     stall_o,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     issue_en_i,
  input  logic [ADDR_W-1:0]        issue_addr_i
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] pend;
  logic wr_ok;
  assign wr_ok = wr_en_i && !(ZERO_REG != 0 && wr_addr_i == ZERO_ADDR);
  // storage: synchronous clear, otherwise one write per cycle
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end
  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_en_i  (wr_en_i),
    .clr_addr_i(wr_addr_i),
    .set_en_i  (issue_en_i),
    .set_addr_i(issue_addr_i),
    .pend_o    (pend)
  );
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic is_zero, hit;
    assign addr = rd_addr_i[g*ADDR_W +: ADDR_W];
    assign is_zero = ZERO_REG != 0 && addr == ZERO_ADDR;
    assign hit = BYPASS != 0 && wr_en_i && wr_addr_i == addr;
    assign rd_data_o[g*DATA_W +: DATA_W] = is_zero ? '0 : hit ? wr_data_i : regs_q[addr];
    assign rd_pending_o[g] = pend[addr] && !hit && !is_zero;
  end
  assign stall_o = |(rd_pending_o & rd_use_i);
endmodule

// File: tb/tb_pipe_regfile.sv
// tb_pipe_regfile: directed checks of read, bypass, zero register, scoreboard and reset
module tb_pipe_regfile;
  import pipe_regfile_pkg::*;
  logic clk = 0, rst_n = 0;
  logic [9:0] rd_addr = '0;
  logic [1:0] rd_use = '0;
  logic wr_en = 0, issue_en = 0;
  rf_addr_t wr_addr = '0, issue_addr = '0;
  rf_data_t wr_data = '0;
  logic [63:0] data_b, data_n;
  logic [1:0] pend_b, pend_n;
  logic stall_b, stall_n;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  pipe_regfile #(.BYPASS(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(rd_addr), .rd_use_i(rd_use),
    .rd_data_o(data_b), .rd_pending_o(pend_b), .stall_o(stall_b),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .issue_en_i(issue_en), .issue_addr_i(issue_addr)
  );
  pipe_regfile #(.BYPASS(0)) dut_n (
    .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(rd_addr), .rd_use_i(rd_use),
    .rd_data_o(data_n), .rd_pending_o(pend_n), .stall_o(stall_n),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .issue_en_i(issue_en), .issue_addr_i(issue_addr)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick;
    rst_n = 1;
    rd_use = 2'b11;
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(a), 5'(a)};
      #1;
      check("rst_data0", data_b[31:0], 0);
      check("rst_data1", data_b[63:32], 0);
      check("rst_pend", 32'(pend_b), 0);
      check("rst_stall", 32'(stall_b), 0);
    end
    tick;
    rd_use = 2'b00;
    rd_addr = {5'd0, 5'd5};
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    #1;
    check("byp_same_cycle", data_b[31:0], 32'hDEADBEEF);
    check("nobyp_old", data_n[31:0], 0);
    tick;
    wr_en = 0;
    #1;
    check("byp_next", data_b[31:0], 32'hDEADBEEF);
    check("nobyp_next", data_n[31:0], 32'hDEADBEEF);
    wr_en = 1; wr_addr = 0; wr_data = 32'h1234;
    issue_en = 1; issue_addr = 0;
    rd_addr = {5'd0, 5'd0};
    #1;
    check("zero_byp", data_b[31:0], 0);
    check("zero_pend_now", 32'(pend_b), 0);
    tick;
    wr_en = 0; issue_en = 0;
    #1;
    check("zero_after_b", data_b[63:32], 0);
    check("zero_after_n", data_n[31:0], 0);
    check("zero_pend_b", 32'(pend_b), 0);
    check("zero_pend_n", 32'(pend_n), 0);
    issue_en = 1; issue_addr = 8;
    tick;
    issue_en = 0;
    rd_addr = {5'd8, 5'd5};
    rd_use = 2'b10;
    #1;
    check("iss8_pend", 32'(pend_b), 2);
    check("iss8_stall", 32'(stall_b), 1);
    check("iss8_data0", data_b[31:0], 32'hDEADBEEF);
    tick;
    check("iss8_hold", 32'(stall_b), 1);
    wr_en = 1; wr_addr = 8; wr_data = 32'h88;
    #1;
    check("wb8_stall_b", 32'(stall_b), 0);
    check("wb8_data_b", data_b[63:32], 32'h88);
    check("wb8_stall_n", 32'(stall_n), 1);
    tick;
    wr_en = 0;
    #1;
    check("wb8_after_pend", 32'(pend_b), 0);
    check("wb8_after_stall_n", 32'(stall_n), 0);
    check("wb8_after_data_n", data_n[63:32], 32'h88);
    issue_en = 1; issue_addr = 9;
    tick;
    issue_en = 0;
    rd_addr = {5'd9, 5'd0};
    #1;
    check("iss9_pend", 32'(pend_b), 2);
    issue_en = 1; issue_addr = 9;
    wr_en = 1; wr_addr = 9; wr_data = 32'h99;
    #1;
    check("both9_pend_b", 32'(pend_b), 0);
    check("both9_data_b", data_b[63:32], 32'h99);
    tick;
    issue_en = 0; wr_en = 0;
    #1;
    check("both9_pend_after", 32'(pend_b), 2);
    check("both9_stall_after", 32'(stall_b), 1);
    check("both9_data_n", data_n[63:32], 32'h99);
    wr_en = 1; wr_addr = 3; wr_data = 32'h3333;
    tick;
    wr_en = 0;
    issue_en = 1; issue_addr = 3;
    tick;
    issue_addr = 7;
    tick;
    issue_en = 0;
    rd_addr = {5'd7, 5'd3};
    rd_use = 2'b11;
    #1;
    check("pre_rst_pend", 32'(pend_n), 3);
    check("pre_rst_data3", data_n[31:0], 32'h3333);
    rst_n = 0;
    wr_en = 1; wr_addr = 3; wr_data = 32'h55;
    tick;
    rst_n = 1; wr_en = 0;
    #1;
    check("post_rst_pend_b", 32'(pend_b), 0);
    check("post_rst_pend_n", 32'(pend_n), 0);
    check("post_rst_stall", 32'(stall_b), 0);
    check("post_rst_data3", data_n[31:0], 0);
    rd_addr = {5'd5, 5'd9};
    #1;
    check("post_rst_data9", data_b[31:0], 0);
    check("post_rst_data5", data_n[63:32], 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
